posit_pack_arbiter: RTL and testbench

POSIT_PACK_ARBITER -- requirements
Module: posit_pack_arbiter

---
 rtl/posit_pack_arbiter_if.sv | 38 +++
 rtl/posit_pack_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_posit_pack_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/posit_pack_arbiter_if.sv
// Handshake and result bus of posit_pack_arbiter: two operand requesters and one result consumer.
// master = requester/consumer side, slave = the arbiter.
interface posit_pack_arbiter_if #(
  parameter int BITS = 32,
  parameter int ES   = 3
);
  logic            req0_valid;
  logic            req0_ready;
  logic [BITS-1:0] req0_frac;
  logic [ES-1:0]   req0_exp;
  logic [BITS-1:0] req0_seed;

  logic            req1_valid;
  logic            req1_ready;
  logic [BITS-1:0] req1_frac;
  logic [ES-1:0]   req1_exp;
  logic [BITS-1:0] req1_seed;

  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_posit;
  logic            out_id;
  logic            busy;

  modport master (
    output req0_valid, req0_frac, req0_exp, req0_seed,
    output req1_valid, req1_frac, req1_exp, req1_seed,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_posit, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_frac, req0_exp, req0_seed,
    input  req1_valid, req1_frac, req1_exp, req1_seed,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_posit, out_id, busy
  );
endinterface

// File: rtl/posit_pack_arbiter.sv
// Two-requester round-robin arbiter sharing one posit packer (regime/exponent/fraction -> posit).
// Optional feature: define POSIT_PACK_SATURATE_EN to clamp the captured seed to +/-(BITS-2).

module posit_pack_core #(
  parameter int BITS = 32,
  parameter int ES   = 3
) (
  input  logic [BITS-1:0] i_frac,
  input  logic [ES-1:0]   i_exp,
  input  logic [BITS-1:0] i_seed,
  output logic [BITS-1:0] o_posit
);
  localparam int             LP_W    = 2 * BITS + ES + 1;
  localparam logic [BITS:0]  LP_FULL = (BITS + 1)'(BITS);

  logic            w_neg;
  logic [BITS:0]   w_run;
  logic [BITS:0]   w_run_lim;
  logic [BITS:0]   w_shamt;
  logic [LP_W-1:0] w_cat;
  logic [LP_W-1:0] w_sh;
  logic            w_unused_lsb;

  // Regime run: seed k>=0 -> k+1 ones then 0; k<0 -> -k zeros then 1.
  always_comb begin
    w_neg = i_seed[BITS-1];
    if (w_neg) begin
      w_run = {1'b0, (~i_seed + 1'b1)};
    end else begin
      w_run = {1'b0, i_seed} + 1'b1;
    end
    w_run_lim = (w_run > LP_FULL) ? LP_FULL : w_run;
    w_shamt   = LP_FULL - w_run_lim;
  end

  // Fill bits above the terminator are shifted out until exactly w_run remain on top.
  assign w_cat        = {{BITS{~w_neg}}, w_neg, i_exp, i_frac};
  assign w_sh         = w_cat << w_shamt;
  assign o_posit      = {1'b0, w_sh[LP_W-1 -: BITS-1]};
  assign w_unused_lsb = ^w_sh[LP_W-BITS:0];
endmodule

// state | meaning
// IDLE  | waiting for a request; ready driven to the winning requester
// PACK  | captured operands drive the packer; result registered at end of cycle
// OUT   | out_valid high, result held until out_ready
module posit_pack_arbiter #(
  parameter int BITS = 32,
  parameter int ES   = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  posit_pack_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_last_grant;
  logic [BITS-1:0] r_frac;
  logic [ES-1:0]   r_exp;
  logic [BITS-1:0] r_seed;
  logic            r_id;
  logic [BITS-1:0] r_out_posit;
  logic            r_out_id;

  logic            w_gnt_id;
  logic            w_accept;
  logic            w_ready0;
  logic            w_ready1;
  logic [BITS-1:0] w_seed;
  logic [BITS-1:0] w_pack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_id    = 1'b0;
    w_accept    = 1'b0;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          w_gnt_id = ~r_last_grant;
        end else if (bus.req1_valid) begin
          w_gnt_id = 1'b1;
        end else begin
          w_gnt_id = 1'b0;
        end
        if (bus.req0_valid || bus.req1_valid) begin
          w_accept    = 1'b1;
          w_ready0    = ~w_gnt_id;
          w_ready1    = w_gnt_id;
          w_state_nxt = ST_PACK;
        end
      end
      ST_PACK: begin
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_frac       <= '0;
      r_exp        <= '0;
      r_seed       <= '0;
      r_id         <= 1'b0;
      r_out_posit  <= '0;
      r_out_id     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt_id;
        r_id         <= w_gnt_id;
        r_frac       <= w_gnt_id ? bus.req1_frac : bus.req0_frac;
        r_exp        <= w_gnt_id ? bus.req1_exp  : bus.req0_exp;
        r_seed       <= w_gnt_id ? bus.req1_seed : bus.req0_seed;
      end
      if (r_state == ST_PACK) begin
        r_out_posit <= w_pack;
        r_out_id    <= r_id;
      end
    end
  end

`ifdef POSIT_PACK_SATURATE_EN
  localparam logic [BITS-1:0] LP_SEED_MAX = BITS'(BITS - 2);
  localparam logic [BITS-1:0] LP_SEED_MIN = BITS'(-(BITS - 2));

  always_comb begin
    w_seed = r_seed;
    if ($signed(r_seed) > $signed(LP_SEED_MAX)) begin
      w_seed = LP_SEED_MAX;
    end else if ($signed(r_seed) < $signed(LP_SEED_MIN)) begin
      w_seed = LP_SEED_MIN;
    end
  end
`else
  assign w_seed = r_seed;
`endif

  posit_pack_core #(
    .BITS (BITS),
    .ES   (ES)
  ) u_pack (
    .i_frac  (r_frac),
    .i_exp   (r_exp),
    .i_seed  (w_seed),
    .o_posit (w_pack)
  );

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.out_valid  = (r_state == ST_OUT);
  assign bus.out_posit  = r_out_posit;
  assign bus.out_id     = r_out_id;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_posit_pack_arbiter.sv
// Directed bench for posit_pack_arbiter at BITS=8, ES=1 with hand-computed posits.
module tb_posit_pack_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cyc;
  int   hits;

  posit_pack_arbiter_if #(.BITS(8), .ES(1)) bus ();

  posit_pack_arbiter #(.BITS(8), .ES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Waits (bounded) for out_valid at a falling edge; returns falling edges waited.
  task automatic expect_out(input string tag, input logic [7:0] posit, input logic id,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 12);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_posit"}, 32'(bus.out_posit), 32'(posit));
    chk({tag, "_id"},    32'(bus.out_id),    32'(id));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_frac = '0; bus.req0_exp = '0; bus.req0_seed = '0;
    bus.req1_valid = 1'b0; bus.req1_frac = '0; bus.req1_exp = '0; bus.req1_seed = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_posit", 32'(bus.out_posit), 32'd0);
    chk("rst_id",    32'(bus.out_id),    32'd0);

    // single request in the first cycle after reset release
    rst_n = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    chk("t1_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("t1_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req0_seed  = 8'h05;
    bus.req0_frac  = 8'hFF;
    chk("t1_busy",      32'(bus.busy),       32'd1);
    chk("t1_pack_vld",  32'(bus.out_valid),  32'd0);
    chk("t1_pack_rdy0", 32'(bus.req0_ready), 32'd0);
    expect_out("t1", 8'h40, 1'b0, cyc);
    chk("t1_lat", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("t1_idle_vld",  32'(bus.out_valid), 32'd0);
    chk("t1_idle_busy", 32'(bus.busy),      32'd0);

    // simultaneous requests right after reset: req0 wins the first tie
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_seed = 8'hFF; bus.req0_exp = '0; bus.req0_frac = '0;
    bus.req1_seed = 8'h01; bus.req1_exp = '0; bus.req1_frac = '0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("t2_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("t2_rdy1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    chk("t2_pack_rdy1", 32'(bus.req1_ready), 32'd0);
    expect_out("t2a", 8'h20, 1'b0, cyc);
    expect_out("t2b", 8'h60, 1'b1, cyc);
    chk("t2_gap", 32'(cyc), 32'd3);

    // both held valid: grants alternate 0,1,0,1 at one result per 3 cycles
    bus.req0_seed = 8'h02; bus.req0_exp = 1'b1; bus.req0_frac = 8'hA0;
    bus.req1_seed = 8'hFE; bus.req1_exp = 1'b1; bus.req1_frac = 8'hC0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_out("t3_0", 8'h76, 1'b0, cyc);
      else            expect_out("t3_1", 8'h1E, 1'b1, cyc);
      chk("t3_gap", 32'(cyc), 32'd3);
    end

    // back-pressure in OUT
    bus.req0_seed = 8'h00; bus.req0_exp = 1'b1; bus.req0_frac = 8'h80;
    @(negedge clk);
    chk("t4_rdy0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    expect_out("t4", 8'h58, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_vld",   32'(bus.out_valid),  32'd1);
      chk("t4_hold_posit", 32'(bus.out_posit),  32'h58);
      chk("t4_hold_id",    32'(bus.out_id),     32'd0);
      chk("t4_hold_rdy",   32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      chk("t4_hold_busy",  32'(bus.busy),       32'd1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    chk("t4_drain_vld",  32'(bus.out_valid), 32'd0);
    chk("t4_drain_busy", 32'(bus.busy),      32'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_stale", 32'(bus.out_valid), 32'd0);

    // reset during PACK discards the transaction
    bus.req0_seed = 8'h01; bus.req0_exp = '0; bus.req0_frac = '0;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    chk("t5_in_pack", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_vld",   32'(bus.out_valid), 32'd0);
    chk("t5_busy",  32'(bus.busy),      32'd0);
    chk("t5_posit", 32'(bus.out_posit), 32'd0);
    chk("t5_id",    32'(bus.out_id),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    chk("t5_no_out", 32'(hits), 32'd0);

    // regime extremes
    bus.req1_seed = 8'h06; bus.req1_exp = '0; bus.req1_frac = '0;
    bus.req1_valid = 1'b1;
    expect_out("t6_pos6", 8'h7F, 1'b1, cyc);
    bus.req1_valid = 1'b0;
    bus.req0_seed = 8'hFA; bus.req0_exp = '0; bus.req0_frac = '0;
    bus.req0_valid = 1'b1;
    expect_out("t6_neg6", 8'h01, 1'b0, cyc);
    bus.req0_valid = 1'b0;
`ifdef POSIT_PACK_SATURATE_EN
    bus.req0_seed = 8'h14;
    bus.req0_valid = 1'b1;
    expect_out("t7_sat_pos", 8'h7F, 1'b0, cyc);
    bus.req0_valid = 1'b0;
    bus.req1_seed = 8'hEC; bus.req1_exp = '0; bus.req1_frac = '0;
    bus.req1_valid = 1'b1;
    expect_out("t7_sat_neg", 8'h01, 1'b1, cyc);
    bus.req1_valid = 1'b0;
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
